mod_exp_engine: RTL and testbench

//  Parametrised sequential RSA modular-exponentiation core: line_out = message^key mod modulus.

---
 rtl/mod_exp_engine_if.sv | 28 ++
 rtl/mod_exp_engine.sv | 146 ++++++++++++++
 tb/tb_mod_exp_engine.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mod_exp_engine_if.sv
// Request/response bundle for the modular-exponentiation core.
// The slave side is the core; the master side is the requester/consumer.
interface mod_exp_engine_if #(
   parameter int WIDTH = 11
);
   logic             in_valid;
   logic             in_ready;
   logic             mode_in;
   logic [WIDTH-1:0] message;
   logic [WIDTH-1:0] public_key;
   logic [WIDTH-1:0] private_key;
   logic [WIDTH-1:0] modulus;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] line_out;
   logic             err_out;
   logic             busy;

   modport slave (
      input  in_valid, mode_in, message, public_key, private_key, modulus, out_ready,
      output in_ready, out_valid, line_out, err_out, busy
   );

   modport master (
      output in_valid, mode_in, message, public_key, private_key, modulus, out_ready,
      input  in_ready, out_valid, line_out, err_out, busy
   );
endinterface

// File: rtl/mod_exp_engine.sv
// Sequential modular exponentiation (right-to-left square-and-multiply) built from
// two shift-add modular multipliers sharing one multiplier bit stream.
module mod_exp_engine #(
   parameter int WIDTH = 11
) (
   input  logic              clk_in,
   input  logic              rst_in,
   mod_exp_engine_if.slave   bus
);
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_MUL,
      S_STEP,
      S_DONE
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_msg;
   logic [WIDTH-1:0] r_key;
   logic [WIDTH-1:0] r_n;
   logic [WIDTH-1:0] r_r;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_pr;
   logic [WIDTH-1:0] r_ps;
   logic [IW-1:0]    r_bit;
   logic [IW-1:0]    r_idx;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_line;
   logic             r_err;
   logic             r_busy;

   logic [WIDTH-1:0] w_pr_next;
   logic [WIDTH-1:0] w_ps_next;
   logic [WIDTH-1:0] w_r_next;

   // One MSB-first shift-add step: p < n and add < n, so 2p+add < 3n fits in WIDTH+2 bits
   // and two conditional subtractions bring it back below n.
   function automatic logic [WIDTH-1:0] mod_acc(input logic [WIDTH-1:0] p,
                                                input logic [WIDTH-1:0] add,
                                                input logic [WIDTH-1:0] n);
      logic [WIDTH+1:0] s;
      s = {1'b0, p, 1'b0} + {2'b00, add};
      if (s >= {2'b00, n}) s = s - {2'b00, n};
      if (s >= {2'b00, n}) s = s - {2'b00, n};
      return s[WIDTH-1:0];
   endfunction

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      w_pr_next = '0;
      w_ps_next = '0;
      w_pr_next = mod_acc(r_pr, r_b[r_bit] ? r_r : '0, r_n);
      w_ps_next = mod_acc(r_ps, r_b[r_bit] ? r_b : '0, r_n);
   end

   assign w_r_next = r_key[r_idx] ? r_pr : r_r;

   // NOTE: only control state is reset; datapath registers are always loaded before being read.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state     <= S_IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_line      <= '0;
         r_err       <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_msg      <= bus.message;
                  r_n        <= bus.modulus;
                  r_key      <= bus.mode_in ? bus.public_key : bus.private_key;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= S_CHECK;
               end
            end
            S_CHECK: begin
               if ((r_n < WIDTH'(2)) || (r_msg >= r_n)) begin
                  r_line      <= '0;
                  r_err       <= 1'b1;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_r     <= WIDTH'(1);
                  r_b     <= r_msg;
                  r_pr    <= '0;
                  r_ps    <= '0;
                  r_idx   <= '0;
                  r_bit   <= IW'(WIDTH-1);
                  r_err   <= 1'b0;
                  r_state <= S_MUL;
               end
            end
            S_MUL: begin
               r_pr <= w_pr_next;
               r_ps <= w_ps_next;
               if (r_bit == '0) r_state <= S_STEP;
               else             r_bit   <= r_bit - IW'(1);
            end
            S_STEP: begin
               r_r   <= w_r_next;
               r_b   <= r_ps;
               r_pr  <= '0;
               r_ps  <= '0;
               r_bit <= IW'(WIDTH-1);
               if (r_idx == IW'(WIDTH-1)) begin
                  r_line      <= w_r_next;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_idx   <= r_idx + IW'(1);
                  r_state <= S_MUL;
               end
            end
            S_DONE: begin
               // in_ready rises only after the output handshake, so a request arriving
               // alongside out_ready waits one more cycle.
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_busy      <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.line_out  = r_line;
   assign bus.err_out   = r_err;
   assign bus.busy      = r_busy;
endmodule

// File: tb/tb_mod_exp_engine.sv
// Directed-vector and scenario bench for mod_exp_engine (WIDTH=11).
module tb_mod_exp_engine;
   localparam int W = 11;

   logic clk_in = 1'b0;
   logic rst_in = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   mod_exp_engine_if #(.WIDTH(W)) bus ();

   mod_exp_engine #(.WIDTH(W)) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .bus    (bus)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic         mode;
      logic [W-1:0] msg;
      logic [W-1:0] pub;
      logic [W-1:0] priv;
      logic [W-1:0] n;
      logic [W-1:0] exp_line;
      logic         exp_err;
      int           exp_lat;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference by repeated multiplication: independent of the square-and-multiply schedule.
   function automatic logic [W-1:0] ref_exp(input int msg, input int key, input int n);
      longint r;
      r = 1;
      for (int i = 0; i < key; i++) r = (r * msg) % n;
      return W'(r);
   endfunction

   task automatic drive(input logic mode, input int msg, input int pub, input int priv, input int n);
      bus.mode_in     = mode;
      bus.message     = W'(msg);
      bus.public_key  = W'(pub);
      bus.private_key = W'(priv);
      bus.modulus     = W'(n);
      bus.in_valid    = 1'b1;
   endtask

   // Returns #1 after the accepting edge with in_valid dropped.
   task automatic wait_accept(input string name);
      int guard;
      guard = 0;
      while (!bus.in_ready && guard < 300) begin
         @(posedge clk_in); #1;
         guard++;
      end
      if (guard >= 300) check({name, "_accept_timeout"}, 1, 0);
      @(posedge clk_in); #1;
      bus.in_valid = 1'b0;
   endtask

   // lat is the edge index (relative to the accept edge) at which out_valid is first sampled high.
   task automatic wait_done(output int lat);
      lat = 1;
      while (!bus.out_valid && lat < 400) begin
         @(posedge clk_in); #1;
         lat++;
      end
   endtask

   task automatic finish_out(input string name);
      bus.out_ready = 1'b1;
      @(posedge clk_in); #1;
      bus.out_ready = 1'b0;
      check({name, "_valid_drop"}, bus.out_valid, 0);
      check({name, "_ready_back"}, bus.in_ready, 1);
   endtask

   task automatic run_req(input string name, input logic mode, input int msg, input int pub,
                          input int priv, input int n, input int exp_line, input logic exp_err,
                          input int exp_lat);
      int lat;
      drive(mode, msg, pub, priv, n);
      wait_accept(name);
      wait_done(lat);
      check({name, "_latency"}, lat, exp_lat);
      check({name, "_line"}, bus.line_out, exp_line);
      check({name, "_err"}, bus.err_out, exp_err);
      finish_out(name);
   endtask

   initial begin
      int lat;
      int seen;
      bus.in_valid    = 1'b0;
      bus.out_ready   = 1'b0;
      bus.mode_in     = 1'b0;
      bus.message     = '0;
      bus.public_key  = '0;
      bus.private_key = '0;
      bus.modulus     = '0;

      //         mode msg   pub   priv  n     line  err lat
      vecs[0]  = '{1'b1, 3,    5,    11,   14,   5,    0, 134};
      vecs[1]  = '{1'b0, 5,    5,    11,   14,   3,    0, 134};
      vecs[2]  = '{1'b1, 9,    0,    7,    14,   1,    0, 134};
      vecs[3]  = '{1'b0, 0,    3,    5,    14,   0,    0, 134};
      vecs[4]  = '{1'b1, 2046, 2,    0,    2047, 1,    0, 134};
      vecs[5]  = '{1'b1, 2,    10,   0,    2047, 1024, 0, 134};
      vecs[6]  = '{1'b1, 2,    11,   0,    2047, 1,    0, 134};
      vecs[7]  = '{1'b1, 1,    2047, 0,    2047, 1,    0, 134};
      vecs[8]  = '{1'b1, 0,    0,    0,    1,    0,    1, 2};
      vecs[9]  = '{1'b1, 14,   5,    0,    14,   0,    1, 2};
      vecs[10] = '{1'b0, 3,    0,    0,    0,    0,    1, 2};
      vecs[11] = '{1'b1, 3,    2047, 0,    14,   3,    0, 134};
      vecs[12] = '{1'b1, 13,   2,    0,    14,   1,    0, 134};
      vecs[13] = '{1'b1, 2046, 3,    0,    2047, 2046, 0, 134};

      repeat (3) @(posedge clk_in);
      #1;
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_line", bus.line_out, 0);
      check("rst_err", bus.err_out, 0);
      check("rst_busy", bus.busy, 0);
      rst_in = 1'b0;
      @(posedge clk_in); #1;

      for (int i = 0; i < 14; i++)
         run_req($sformatf("vec%0d", i), vecs[i].mode, int'(vecs[i].msg), int'(vecs[i].pub),
                 int'(vecs[i].priv), int'(vecs[i].n), int'(vecs[i].exp_line),
                 vecs[i].exp_err, vecs[i].exp_lat);

      // Round trip with pub=5 / priv=11 over N=14.
      for (int m = 0; m < 14; m++) begin
         int c;
         c = int'(ref_exp(m, 5, 14));
         run_req($sformatf("enc%0d", m), 1'b1, m, 5, 3, 14, c, 1'b0, 134);
         run_req($sformatf("dec%0d", m), 1'b0, c, 7, 11, 14, m, 1'b0, 134);
      end

      // Backpressure: result held, new request pending until after the output handshake.
      drive(1'b1, 3, 5, 11, 14);
      wait_accept("bp");
      wait_done(lat);
      check("bp_latency", lat, 134);
      drive(1'b0, 5, 5, 11, 14);
      for (int k = 0; k < 20; k++) begin
         @(posedge clk_in); #1;
         check("bp_hold_valid", bus.out_valid, 1);
         check("bp_hold_line", bus.line_out, 5);
         check("bp_hold_ready", bus.in_ready, 0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk_in); #1;
      bus.out_ready = 1'b0;
      check("bp_valid_drop", bus.out_valid, 0);
      check("bp_ready_up", bus.in_ready, 1);
      check("bp_busy_low", bus.busy, 0);
      @(posedge clk_in); #1;
      bus.in_valid = 1'b0;
      check("bp_accepted_ready", bus.in_ready, 0);
      check("bp_accepted_busy", bus.busy, 1);
      wait_done(lat);
      check("bp2_latency", lat, 134);
      check("bp2_line", bus.line_out, 3);
      check("bp2_err", bus.err_out, 0);
      finish_out("bp2");

      // Reset in the middle of an operation.
      drive(1'b1, 3, 5, 11, 14);
      wait_accept("rmid");
      repeat (49) @(posedge clk_in);
      #1;
      rst_in = 1'b1;
      @(posedge clk_in); #1;
      rst_in = 1'b0;
      check("rmid_ready", bus.in_ready, 1);
      check("rmid_busy", bus.busy, 0);
      seen = 0;
      for (int k = 0; k < 150; k++) begin
         @(posedge clk_in); #1;
         if (bus.out_valid) seen = 1;
      end
      check("rmid_no_valid", seen, 0);
      run_req("rmid_next", 1'b0, 5, 0, 11, 14, 3, 1'b0, 134);

      // Random operands against the reference model.
      for (int k = 0; k < 200; k++) begin
         int n, msg, key, other;
         logic mode;
         n     = int'($urandom_range(2047, 2));
         msg   = int'($urandom_range(n - 1, 0));
         key   = int'($urandom_range(2047, 0));
         other = int'($urandom_range(2047, 0));
         mode  = 1'($urandom_range(1, 0));
         if (mode)
            run_req($sformatf("rnd%0d", k), mode, msg, key, other, n,
                    int'(ref_exp(msg, key, n)), 1'b0, 134);
         else
            run_req($sformatf("rnd%0d", k), mode, msg, other, key, n,
                    int'(ref_exp(msg, key, n)), 1'b0, 134);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
